// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: soft-reset request in, staged domain resets and status out.
// The sequencer connects through the master modport, consumers through slave.
interface reset_sequencer_if #(
    parameter int unsigned STAGES = 4
);
    logic              i_soft_rst;
    logic [STAGES-1:0] o_rst;
    logic              o_ready;
    logic [7:0]        o_soft_count;

    modport master (
        input  i_soft_rst,
        output o_rst,
        output o_ready,
        output o_soft_count
    );

    modport slave (
        output i_soft_rst,
        input  o_rst,
        input  o_ready,
        input  o_soft_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes deassertion of the clock generator's reset,
// holds every domain in reset for HOLD_CYCLES, then releases the o_rst bits
// one at a time (bit 0 first) every STAGE_GAP cycles. A soft reset in RUN
// restarts the hold/release sequence without going back through SYNC.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGES      = 4,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    reset_sequencer_if.master    bus
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAGES-1:0]  rst_q, rst_d;
    logic [STAGES-1:0]  rst_next_stage;
    logic               ready_q, ready_d;
    logic [7:0]         soft_cnt_q, soft_cnt_d;
    logic               hold_done;
    logic               gap_done;

    // Deassertion synchronizer: ones shift in once i_rst is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign gap_done  = (cnt_q == CNT_W'(STAGE_GAP - 1));

    // Resets are thermometer-coded with the asserted bits at the top, so
    // releasing the next domain in index order is a left shift by one.
    assign rst_next_stage = rst_q << 1;

    // Sequencer state register and all output flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_SYNC;
            cnt_q      <= '0;
            rst_q      <= '1;
            ready_q    <= 1'b0;
            soft_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_q      <= rst_d;
            ready_q    <= ready_d;
            soft_cnt_q <= soft_cnt_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_d      = rst_q;
        ready_d    = ready_q;
        soft_cnt_d = soft_cnt_q;

        case (state_q)
            ST_SYNC: begin
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end

            ST_HOLD: begin
                if (hold_done) begin
                    cnt_d = '0;
                    rst_d = rst_next_stage;
                    if (rst_next_stage == '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (gap_done) begin
                    cnt_d = '0;
                    rst_d = rst_next_stage;
                    if (rst_next_stage == '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.i_soft_rst) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (soft_cnt_q != 8'hFF) begin
                        soft_cnt_d = soft_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign bus.o_rst        = rst_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_soft_count = soft_cnt_q;

    // Ready mirrors "no domain in reset", and released bits are always a
    // contiguous run starting at bit 0.
    a_ready_consistent: assert property (
        @(posedge i_clk) disable iff (i_rst) ready_q == (rst_q == '0));
    a_release_order: assert property (
        @(posedge i_clk) disable iff (i_rst) ((~rst_q) & ((~rst_q) + 1'b1)) == '0);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: two instances (default and corner parameters) driven
// with directed and random soft/hard resets, compared every cycle against a
// schedule-based model: each instance's outputs follow from the edge count
// since reset release and the edge on which stage 0 is due to release.
module tb_reset_sequencer;

    localparam int A_SYNC = 2, A_HOLD = 16, A_STAGES = 4, A_GAP = 4;
    localparam int B_SYNC = 3, B_HOLD = 1,  B_STAGES = 1, B_GAP = 1;
    localparam int A_T0 = A_SYNC + 1 + A_HOLD;
    localparam int B_T0 = B_SYNC + 1 + B_HOLD;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic chk_on = 1'b0;
    logic done_b = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.STAGES(A_STAGES)) if_a ();
    reset_sequencer_if #(.STAGES(B_STAGES)) if_b ();

    reset_sequencer #(
        .SYNC_STAGES(A_SYNC),
        .HOLD_CYCLES(A_HOLD),
        .STAGES(A_STAGES),
        .STAGE_GAP(A_GAP)
    ) dut_a (
        .i_clk(clk),
        .i_rst(rst_a),
        .bus(if_a)
    );

    reset_sequencer #(
        .SYNC_STAGES(B_SYNC),
        .HOLD_CYCLES(B_HOLD),
        .STAGES(B_STAGES),
        .STAGE_GAP(B_GAP)
    ) dut_b (
        .i_clk(clk),
        .i_rst(rst_b),
        .bus(if_b)
    );

    // Model state: edges since release, edge of stage-0 release, counts.
    int e_a = 0, t0_a = A_T0, cnt_a = 0, tot_a = 0;
    int e_b = 0, t0_b = B_T0, cnt_b = 0;

    function automatic logic [7:0] exp_rst(int e, int t0, int stages, int gap);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < stages; k++) r[k] = (e < t0 + gap * k);
        return r;
    endfunction

    function automatic logic [7:0] exp_ready(int e, int t0, int stages, int gap);
        return (e >= t0 + gap * (stages - 1)) ? 8'd1 : 8'd0;
    endfunction

    // Model for the default instance.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            e_a <= 0; t0_a <= A_T0; cnt_a <= 0; tot_a <= 0;
        end else begin
            e_a <= e_a + 1;
            if (if_a.i_soft_rst && e_a >= t0_a + A_GAP * (A_STAGES - 1)) begin
                t0_a  <= e_a + 1 + A_HOLD;
                cnt_a <= (cnt_a >= 255) ? 255 : cnt_a + 1;
                tot_a <= tot_a + 1;
            end
        end
    end

    // Model for the corner instance.
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            e_b <= 0; t0_b <= B_T0; cnt_b <= 0;
        end else begin
            e_b <= e_b + 1;
            if (if_b.i_soft_rst && e_b >= t0_b + B_GAP * (B_STAGES - 1)) begin
                t0_b  <= e_b + 1 + B_HOLD;
                cnt_b <= (cnt_b >= 255) ? 255 : cnt_b + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_rst",   8'(if_a.o_rst),   exp_rst(e_a, t0_a, A_STAGES, A_GAP));
            check("a_ready", 8'(if_a.o_ready), exp_ready(e_a, t0_a, A_STAGES, A_GAP));
            check("a_count", if_a.o_soft_count, 8'(cnt_a));
            check("b_rst",   8'(if_b.o_rst),   exp_rst(e_b, t0_b, B_STAGES, B_GAP));
            check("b_ready", 8'(if_b.o_ready), exp_ready(e_b, t0_b, B_STAGES, B_GAP));
            check("b_count", if_b.o_soft_count, 8'(cnt_b));
        end
    end

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting, got no progress expected progress", nm);
    endtask

    // Advance until instance A's model has seen edge n (phase: posedge+2).
    task automatic goto_a(input int n);
        int g = 0;
        while (e_a < n) begin
            @(posedge clk); #2;
            g++;
            if (g > 20000) begin timeout_fail("goto_a"); return; end
        end
    endtask

    task automatic goto_b(input int n);
        int g = 0;
        while (e_b < n) begin
            @(posedge clk); #2;
            g++;
            if (g > 20000) begin timeout_fail("goto_b"); return; end
        end
    endtask

    task automatic reset_a(input int n);
        rst_a = 1'b1;
        repeat (n) @(posedge clk);
        #2;
        rst_a = 1'b0;
    endtask

    task automatic lit_a(input string nm, input logic [3:0] r, input logic rdy);
        check({nm, "_rst"},   8'(if_a.o_rst),   8'(r));
        check({nm, "_ready"}, 8'(if_a.o_ready), 8'(rdy));
    endtask

    initial begin
        rst_a = 1'b1;
        if_a.i_soft_rst = 1'b0;
        #7 chk_on = 1'b1;
    end

    // Default instance: directed scenarios, random phase, saturation.
    initial begin
        int g;
        #1;
        // Power-up schedule.
        reset_a(5);
        goto_a(18); lit_a("pu18", 4'hF, 1'b0);
        goto_a(19); lit_a("pu19", 4'hE, 1'b0);
        goto_a(23); lit_a("pu23", 4'hC, 1'b0);
        goto_a(27); lit_a("pu27", 4'h8, 1'b0);
        goto_a(30); lit_a("pu30", 4'h8, 1'b0);
        goto_a(31); lit_a("pu31", 4'h0, 1'b1);
        check("pu_count", if_a.o_soft_count, 8'd0);

        // Soft reset in RUN at edge 40.
        goto_a(39); if_a.i_soft_rst = 1'b1;
        goto_a(40); if_a.i_soft_rst = 1'b0;
        lit_a("sr40", 4'hF, 1'b0);
        check("sr_count", if_a.o_soft_count, 8'd1);
        goto_a(55); lit_a("sr55", 4'hF, 1'b0);
        goto_a(56); lit_a("sr56", 4'hE, 1'b0);
        goto_a(60); lit_a("sr60", 4'hC, 1'b0);
        goto_a(64); lit_a("sr64", 4'h8, 1'b0);
        goto_a(67); lit_a("sr67", 4'h8, 1'b0);
        goto_a(68); lit_a("sr68", 4'h0, 1'b1);

        // Async reset mid-release between edges 24 and 25.
        reset_a(2);
        goto_a(24); lit_a("mr24", 4'hC, 1'b0);
        rst_a = 1'b1;
        #1;
        lit_a("mr_async", 4'hF, 1'b0);
        check("mr_count", if_a.o_soft_count, 8'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_a = 1'b0;
        goto_a(19); lit_a("mr19", 4'hE, 1'b0);
        goto_a(23); lit_a("mr23", 4'hC, 1'b0);
        goto_a(27); lit_a("mr27", 4'h8, 1'b0);
        goto_a(31); lit_a("mr31", 4'h0, 1'b1);

        // Reset glitch shorter than a clock period, away from clock edges.
        goto_a(40);
        rst_a = 1'b1;
        #1;
        lit_a("gl_async", 4'hF, 1'b0);
        #1;
        rst_a = 1'b0;
        goto_a(18); lit_a("gl18", 4'hF, 1'b0);
        goto_a(19); lit_a("gl19", 4'hE, 1'b0);
        goto_a(31); lit_a("gl31", 4'h0, 1'b1);

        // Random soft requests with occasional reset glitches and holds.
        reset_a(2);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if_a.i_soft_rst = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_a = 1'b1; #1; rst_a = 1'b0;
            end else if ($urandom_range(0, 699) == 0) begin
                rst_a = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2;
                rst_a = 1'b0;
            end
        end
        if_a.i_soft_rst = 1'b0;

        // Soft held through SYNC/HOLD/RELEASE is ignored.
        reset_a(3);
        goto_a(9); if_a.i_soft_rst = 1'b1;
        goto_a(19); lit_a("ig19", 4'hE, 1'b0);
        goto_a(23); lit_a("ig23", 4'hC, 1'b0);
        goto_a(27); lit_a("ig27", 4'h8, 1'b0);
        goto_a(30); check("ig_count", if_a.o_soft_count, 8'd0);
        if_a.i_soft_rst = 1'b0;
        goto_a(31); lit_a("ig31", 4'h0, 1'b1);

        // Held high in RUN: restarts every 29 edges.
        goto_a(35); if_a.i_soft_rst = 1'b1;
        goto_a(36); lit_a("hh36", 4'hF, 1'b0);
        check("hh36_count", if_a.o_soft_count, 8'd1);
        goto_a(64); lit_a("hh64", 4'h0, 1'b1);
        goto_a(65); lit_a("hh65", 4'hF, 1'b0);
        check("hh65_count", if_a.o_soft_count, 8'd2);
        goto_a(94); check("hh94_count", if_a.o_soft_count, 8'd3);

        // Saturation: keep restarting until 300 soft resets honoured.
        g = 0;
        while (tot_a < 300 && g < 20000) begin
            @(posedge clk); #2;
            g++;
        end
        if (tot_a < 300) timeout_fail("saturation");
        if_a.i_soft_rst = 1'b0;
        goto_a(t0_a + A_GAP * (A_STAGES - 1));
        lit_a("sat_run", 4'h0, 1'b1);
        check("sat_count", if_a.o_soft_count, 8'd255);

        g = 0;
        while (!done_b && g < 20000) begin
            @(posedge clk);
            g++;
        end
        if (!done_b) timeout_fail("done_b");
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Corner instance: stage 0 and ready change together at edge 5.
    initial begin
        rst_b = 1'b1;
        if_b.i_soft_rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_b = 1'b0;
        goto_b(4);
        check("b4_rst",   8'(if_b.o_rst),   8'd1);
        check("b4_ready", 8'(if_b.o_ready), 8'd0);
        goto_b(5);
        check("b5_rst",   8'(if_b.o_rst),   8'd0);
        check("b5_ready", 8'(if_b.o_ready), 8'd1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if_b.i_soft_rst = ($urandom_range(0, 2) == 0);
        end
        if_b.i_soft_rst = 1'b0;
        done_b = 1'b1;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset-release controller that sits directly downstream of the board clock generator. It takes the generator's PLL-lock-derived reset and the generated core clock, synchronizes reset deassertion, and holds all domains in reset for a programmable settle time. It then releases up to eight reset outputs one at a time, in a fixed order (e.g. interconnect, cores, emitter/UART), and reports when the system is fully out of reset. A synchronous soft-reset request from logic can restart the sequence without losing PLL lock.

## Interface

- SYNC_STAGES, 2: depth of the reset-deassertion synchronizer; legal range ≥2.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after synchronization; legal range ≥1.
- STAGES, 4: number of reset outputs; legal range 1..8.
- STAGE_GAP, 4: cycles between consecutive stage releases; legal range ≥1.

- i_clk  input  1  generated core clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset (clock generator's reset output).
- i_soft_rst  input  1  synchronous soft-reset request; honoured only in RUN.
- o_rst  output  STAGES  per-domain active-high resets; bit 0 released first.
- o_ready  output  1  high when every o_rst bit is deasserted.
- o_soft_count  output  8  saturating count of honoured soft resets.

## Operation

- Reset (i_rst=1), applied asynchronously:
  - o_rst = all ones, o_ready = 0, o_soft_count = 0.
  - Synchronizer cleared; FSM = SYNC; counters = 0.
- Synchronizer: SYNC_STAGES flops, reset to 0, shifting in 1 each edge. Its last bit is the synchronized "clear" signal.
- FSM states: SYNC, HOLD, RELEASE, RUN.
  - SYNC: wait for the synchronizer's last bit = 1. On the first edge where it is sampled high, go to HOLD with cnt=0.
  - HOLD: cnt increments each edge. On the edge where cnt==HOLD_CYCLES-1:
    - clear o_rst[0] and reset cnt to 0;
    - if STAGES==1, go to RUN and set o_ready=1;
    - otherwise go to RELEASE with idx=1.
  - RELEASE: cnt increments each edge. On the edge where cnt==STAGE_GAP-1:
    - clear o_rst[idx], reset cnt to 0, increment idx;
    - if idx was STAGES-1, go to RUN and set o_ready=1 on that same edge.
  - RUN: outputs stable. i_soft_rst=1 sampled on an edge causes, on that edge:
    - o_rst = all ones, o_ready = 0;
    - FSM to HOLD with cnt=0;
    - o_soft_count increments, saturating at 255.
- i_soft_rst is ignored in SYNC, HOLD and RELEASE; it neither restarts the sequence nor counts.
- o_rst bits deassert strictly in index order and never glitch. Every output is a flop.
- o_ready == (o_rst == 0) at all times.
- o_soft_count is cleared only by i_rst.

## Timing

- Edge numbering: edge 1 is the first rising edge of i_clk with i_rst low.
- Release schedule after i_rst:
  - o_rst[0] falls at edge SYNC_STAGES+1+HOLD_CYCLES;
  - o_rst[k] falls STAGE_GAP·k edges after that;
  - o_ready rises on the same edge as o_rst[STAGES-1].
- Defaults: o_rst[0..3] fall at edges 19, 23, 27, 31; o_ready rises at edge 31.
- Soft reset sampled at edge E:
  - o_rst all high and o_ready low after edge E;
  - o_rst[0] falls at edge E+HOLD_CYCLES, subsequent stages every STAGE_GAP edges;
  - defaults: edges E+16, E+20, E+24, E+28.
- Mid-sequence i_rst assertion: all outputs go to reset values immediately, without a clock edge. The full sequence restarts from SYNC once i_rst is released.
- i_rst glitch shorter than a clock period: still treated as a full reset. The asynchronous clear must take effect.
- Assertion of any o_rst is asynchronous (i_rst) or next-edge (soft). Deassertion is always synchronous to i_clk.

## Test plan

- Power-up, defaults: hold i_rst=1 for 5 cycles, release. Require o_rst=4'hF through edge 18; then 4'hE at 19, 4'hC at 23, 4'h8 at 27, 4'h0 at 31; o_ready=1 from edge 31; o_soft_count=0.
- Async reset mid-release: release i_rst, then assert it between edges 24 and 25. Require o_rst=4'hF and o_ready=0 before edge 25; after a second release, the schedule repeats exactly (19/23/27/31).
- Soft reset in RUN: pulse i_soft_rst at edge 40. Require o_rst=4'hF after edge 40; releases at 56, 60, 64, 68; o_soft_count=1.
- Soft reset ignored outside RUN: hold i_soft_rst=1 from edge 10 to 30. Require the default schedule to be unchanged and o_soft_count=0. Then hold it high in RUN and require restarts every 29 edges.
- Saturation: issue 300 soft resets, each after reaching RUN. Require o_soft_count=255 and no wrap.
- Parameter corners: STAGES=1, HOLD_CYCLES=1, SYNC_STAGES=3, STAGE_GAP=1. Require o_rst[0] and o_ready to change together at edge 5.
